// File: rtl/fft_pipe_ctrl.sv
// Frame-control wrapper for a fixed-latency FFT datapath.
// Launch tokens track frames in flight; results are captured into a credit-limited result FIFO.
module fft_pipe_ctrl #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned LATENCY = 35,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pipe_en,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [CNT_W-1:0] used
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [LATENCY-1:0] tok_q, tok_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]   used_q, used_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic issue;
    logic pop;
    logic cap;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign pop       = out_valid & out_ready;
    // A pop frees a credit in the same cycle, so a full wrapper can still accept a launch.
    assign in_ready  = !flush && ((used_q < FULL_CNT) || pop);
    assign issue     = in_valid & in_ready;
    assign pipe_en   = issue;
    assign cap       = tok_q[LATENCY-1];
    assign out_valid = (fifo_cnt_q != '0);
    assign busy      = (used_q != '0);
    assign used      = used_q;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        tok_d      = tok_q << 1;
        tok_d[0]   = issue;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        used_d     = used_q;

        if (cap) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({cap, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        unique case ({issue, pop})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase

        // Dropping the tokens is what keeps late results of flushed frames out of the FIFO.
        if (flush) begin
            tok_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            used_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tok_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            used_q     <= '0;
        end else begin
            tok_q      <= tok_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            used_q     <= used_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap && !flush) begin
            mem_q[wr_ptr_q] <= pipe_data;
        end
    end

endmodule

// File: doc/fft_pipe_ctrl.md
# fft_pipe_ctrl

Parametrised frame-control wrapper for the fixed-latency pipelined FFT output datapaths. It generalises the single-shot start/valid/busy counter to any pipeline latency and supports back-to-back frame issue. Results are captured into a DEPTH-entry result FIFO, so a consumer can apply backpressure with a ready/valid handshake. It sits between the frame scheduler and the per-bin FFT datapath instance, and launches the datapath without stalling it.

## Interface

- WIDTH, 64: result word width (real and imaginary 32 bits each, packed {real, imag}).
- LATENCY, 35: datapath latency in clock cycles from launch to result; legal range is ≥1.
- DEPTH, 4: result FIFO entries; this is also the credit limit on frames in flight plus stored; legal range is ≥1.
- CNT_W, $clog2(DEPTH+1): width of `used`.
- clk  in  1  single clock; all registers are rising-edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- flush  in  1  synchronous clear of tokens, FIFO and credits.
- in_valid  in  1  scheduler requests a frame launch.
- in_ready  out  1  launch accepted this cycle when high with in_valid.
- pipe_en  out  1  launch strobe to the datapath; equals in_valid & in_ready.
- pipe_data  in  WIDTH  datapath result, valid LATENCY cycles after the launch.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  WIDTH  FIFO head; meaningful only while out_valid is high.
- busy  out  1  any frame in flight or stored.
- used  out  CNT_W  in-flight token count plus FIFO occupancy.

## Operation

- Definitions: issue = in_valid & in_ready; pop = out_valid & out_ready.
- Token pipe: tok[LATENCY-1:0], with tok[0] <= issue and tok[i] <= tok[i-1].
  - cap = tok[LATENCY-1].
  - When cap is high, pipe_data is written to the FIFO tail at that edge.
- FIFO behaviour:
  - Registered, first-in first-out, no bypass; out_data is the head entry.
  - Read and write pointers wrap modulo DEPTH.
  - A simultaneous write and pop is legal at any occupancy, including full.
- Credit counter `used`:
  - +1 on issue, -1 on pop; unchanged when both occur in the same cycle.
  - The count never exceeds DEPTH, so the FIFO can never overflow and a write is never dropped.
- in_ready = !flush && ((used < DEPTH) || pop); this allows issue in the same cycle as a pop when at the limit.
- busy = (used != 0).
- out_valid = (FIFO count != 0).
- flush (while reset is high):
  - At the next edge, clears tok, both FIFO pointers, the FIFO count and used.
  - in_ready is 0 while flush is high, so no issue occurs.
  - A cap occurring at the flush edge is discarded.
  - Results of flushed frames that arrive later are never captured, because their tokens are gone.
- Reset (reset low): asynchronously clears all registers, including tok, the pointers, the FIFO count and used.
- Storage array contents need no reset.

## Timing

- Reset values: out_valid 0, busy 0, used 0, pipe_en 0, in_ready 1 (when flush is low), out_data 0.
- Issue sampled at edge n:
  - pipe_data is sampled at edge n+LATENCY.
  - out_valid goes high after edge n+LATENCY.
  - Minimum issue-to-out_valid latency is therefore LATENCY cycles.
- Throughput is one frame per cycle when out_ready is held high and DEPTH ≥ LATENCY+1.
- Otherwise, sustained throughput is DEPTH frames per LATENCY+1 cycles.
- Results leave the FIFO in issue order, with no reordering.
- Pop at edge m: the next head is visible after edge m. If empty, out_valid drops after edge m.
- Reset asserted mid-frame: all outputs take their reset values without waiting for a clock edge. Operation resumes on the first edge after reset is released.
- Simultaneous flush and reset: reset dominates.

## Test plan

- Single frame, LATENCY=35, DEPTH=4:
  - Stimulus: issue at edge 0; drive pipe_data=0x0000_0001_0000_0002 before edge 35; out_ready=1.
  - Required: pipe_en high for 1 cycle; out_valid after edge 35 with out_data equal to that value; busy 1 from edge 0 until the pop at edge 36.
- Backpressure, out_ready=0:
  - Stimulus: in_valid held high.
  - Required: issues at edges 0–3; used=4; in_ready 0 from edge 4.
  - Required: captures occur at edges 35–38.
  - Stimulus: raise out_ready at edge 40.
  - Required: data is popped in issue order at edges 40–43; a 5th issue occurs at edge 40.
- Full plus pop plus issue in one cycle:
  - Stimulus: used=4 and out_ready=1 in the same cycle.
  - Required: in_ready=1, issue accepted, used stays 4.
- Flush mid-flight:
  - Stimulus: issues at edges 0 and 1; flush high at edge 10.
  - Required: used=0 and busy=0 after edge 10; out_valid never rises; pipe_data at edges 35 and 36 is ignored.
- Async reset:
  - Stimulus: pull reset low between edges while out_valid=1 and used=3.
  - Required: out_valid, busy and used go to 0 immediately, before the next edge.
- Corner case, LATENCY=1, DEPTH=1, in_valid and out_ready held high:
  - Required: issues at edges 0, 2, 4, …; out_valid after edges 1, 3, 5.
